fft_input_loader: RTL
=====================

Name: fft_input_loader

Overview:
- Writer-side counterpart to the FFT core's stage-0 read path.
- Accepts a valid/ready stream of complex samples and writes each frame of 1024 samples into the mem1a/mem1b ping-pong banks, in the layout the stage-0 butterfly reads expect:
  - sample n < 512 → mem1a[n]
  - sample n ≥ 512 → mem1b[n−512]
- Hands each completed frame to the FFT core with a start pulse, then blocks input until the core reports done.
- Sits between the ADC/sample front-end and the FFT core/memory write arbitration.

Parameters:
- DATA_W, 32, complex sample width ({re[15:0], im[15:0]}), passed through unmodified.
- ADDR_W, 9, per-bank address width; N = 2^(ADDR_W+1) = 1024 samples per frame.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  loader can accept a sample this cycle.
- i_data  in  DATA_W  input sample.
- i_last  in  1  marks final sample of a frame; qualified by i_valid & o_ready.
- o_wr_en  out  2  bank write enables; bit0 = mem1a, bit1 = mem1b; at most one bit high.
- o_wr_addr  out  ADDR_W  write address, shared by both banks.
- o_wr_data  out  DATA_W  write data.
- o_start  out  1  one-cycle pulse: frame fully written, FFT may begin.
- i_done  in  1  one-cycle pulse from FFT core: mem1 is free for the next frame.
- o_err_len  out  1  one-cycle pulse on a frame length error.
- o_frame_cnt  out  16  count of frames handed to the core; wraps at 65535→0.

Behaviour:
- Reset (async assert, sync release):
  - State = LOAD; sample counter = 0.
  - o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0.
  - o_start = 0, o_err_len = 0, o_frame_cnt = 0.
- Handshake:
  - A sample is accepted when i_valid & o_ready.
  - o_ready = (state == LOAD); it is a function of registered state only, with no combinational path from i_valid.
- Write path:
  - All memory outputs are registered: a sample accepted in cycle t appears on o_wr_en/o_wr_addr/o_wr_data in cycle t+1.
  - o_wr_en = 0 in any cycle following a cycle with no acceptance.
- Mapping: with counter n (10 bits) at acceptance:
  - o_wr_addr = n[8:0].
  - o_wr_en = n[9] ? 2'b10 : 2'b01.
  - Counter increments by 1 per accepted sample.
- States:
  - LOAD: accept samples.
    - Accept with n == 1023 → counter := 0, go to START.
    - Accept with i_last = 1 and n < 1023 → short frame: o_err_len pulses in t+1; counter := 0; stay in LOAD; no o_start. Samples already written are left stale and are overwritten by the next frame.
    - Accept with n == 1023 and i_last = 0 → long/misaligned frame: o_err_len pulses in t+1, but the frame is still complete and proceeds to START. The next sample starts a new frame at n = 0.
  - START (one cycle, entered in t+1, concurrent with the final write):
    - o_ready = 0.
    - o_start pulses in cycle t+2, so it is asserted strictly after the last write is registered.
    - o_frame_cnt increments in the same cycle as o_start.
    - Go to BUSY.
  - BUSY:
    - o_ready = 0; wait for i_done, then go to LOAD; o_ready is high the cycle after i_done.
    - i_done in any other state is ignored.
- Simultaneous events: short-frame i_last on sample 1023 is not possible; n == 1023 takes precedence, so the frame completes with no error.
- Reset mid-frame or mid-BUSY:
  - All state clears immediately; the partial frame is abandoned and no o_start is issued.
  - o_frame_cnt returns to 0.
- Widths:
  - Counter is 10 bits; wrap from 1023 to 0 is explicit.
  - o_frame_cnt wraps modulo 2^16.

Test Plan:
- Nominal frame: drive 1024 back-to-back samples, data = index, i_last on index 1023.
  - Expected: mem1a[k] = k and mem1b[k] = 512+k for all k.
  - Expected: exactly 1024 single-bank writes, o_start one cycle after the last write, o_frame_cnt = 1, o_ready = 0 until i_done.
- Backpressure/gaps: random i_valid duty of 30%, and i_valid held high during BUSY.
  - Expected: no writes while o_ready = 0; no sample lost or duplicated; address sequence contiguous 0..511 on a, then 0..511 on b.
- Short frame: i_last on sample 99.
  - Expected: o_err_len pulse one cycle after acceptance; no o_start.
  - Expected: next sample is written to mem1a[0]; a following full frame completes normally with o_frame_cnt = 1.
- Missing last: 1024 samples with i_last = 0 throughout.
  - Expected: o_err_len and o_start both pulse, o_frame_cnt = 1.
  - After i_done, the next sample is written to mem1a[0].
- Reset mid-operation: assert i_rst_n low at sample 700, and separately during BUSY.
  - Expected: all outputs 0 asynchronously, o_frame_cnt = 0, o_ready = 1 after release, next write goes to mem1a[0].
- Stray i_done: pulse i_done during LOAD at sample 10.
  - Expected: no state change; the frame continues and completes at sample 1023.

Source files
------------

// File: rtl/fft_input_loader.sv
// Streams 1024-sample frames into the mem1a/mem1b stage-0 banks, then hands
// the frame to the FFT core with o_start and holds off input until i_done.
module fft_input_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic [1:0]        o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_start,
  input  logic              i_done,
  output logic              o_err_len,
  output logic [15:0]       o_frame_cnt
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_BUSY
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = '1;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [1:0]          wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                start_q, start_d;
  logic                err_q, err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                accept;

  // Ready depends only on registered state, never on i_valid.
  assign o_ready = (state_q == S_LOAD);
  assign accept  = i_valid & o_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_d     = 2'b00;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          wr_en_d   = cnt_q[ADDR_W] ? 2'b10 : 2'b01;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = i_data;
          if (cnt_q == CNT_MAX) begin
            // A full frame always completes; a missing i_last only flags it.
            cnt_d   = '0;
            err_d   = ~i_last;
            state_d = S_START;
          end else if (i_last) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_START: begin
        start_d     = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = S_BUSY;
      end
      S_BUSY: begin
        if (i_done) begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      wr_en_q     <= 2'b00;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_start     = start_q;
  assign o_err_len   = err_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule
